// File: rtl/zigbee_pkg.sv
// 802.15.4 O-QPSK shared definitions: PN table, FSM states.
// Chip vectors use bit k as chip c_k (c0 is transmitted first).
package zigbee_pkg;

    localparam int NB_P_MIN = 4;

    // Symbol 0 chips written c0 (MSB) .. c31 (LSB).
    localparam logic [31:0] PN_SYM0 = 32'hD9C3_522E;

    typedef enum logic {
        IDLE,
        RUN
    } tx_state_t;

    // Returns chips with bit k = c_k for the given data symbol.
    function automatic logic [31:0] pn_chips(input logic [3:0] sym);
        logic [31:0] base;
        logic [63:0] dbl;
        logic [31:0] r;
        for (int k = 0; k < 32; k++) begin
            base[k] = PN_SYM0[31-k];
        end
        // right shift in chip order is a left rotate of the bit vector
        dbl = {base, base} << {sym[2:0], 2'b00};
        r   = dbl[63:32];
        if (sym[3]) begin
            r = r ^ 32'hAAAA_AAAA;
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_pn_lut.sv
// Symbol-to-chip lookup: combinational 4-bit to 32-chip PN map.
// Output bit k is the chip sent in chip slot k.
module tx_pn_lut
    import zigbee_pkg::*;
(
    input  logic [3:0]  sym_i,
    output logic [31:0] chips_o
);

    assign chips_o = pn_chips(sym_i);

endmodule

// File: rtl/tx_chip_gen.sv
// O-QPSK chip timing generator and DSSS spreader.
// Even chips go to I, odd chips to Q, one chip period apart.
module tx_chip_gen
    import zigbee_pkg::*;
#(
    parameter int NB_P_W = 6
)
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tick,
    input  logic [NB_P_W-1:0] i_nb_P,
    input  logic [3:0]        i_sym,
    input  logic              i_sym_valid,
    output logic              o_sym_ready,
    output logic              o_chip_i,
    output logic              o_chip_q,
    output logic              o_en_i,
    output logic              o_en_q,
    output logic              o_busy
);

    localparam logic [NB_P_W-1:0] ONE       = NB_P_W'(1);
    localparam logic [NB_P_W-1:0] NBP_FLOOR = NB_P_W'(NB_P_MIN);

    tx_state_t         state_q, state_d;
    logic [NB_P_W-1:0] cnt_q, cnt_d;
    logic [NB_P_W-1:0] nbp_q, nbp_d;
    logic [4:0]        idx_q, idx_d;
    logic [31:0]       sr_q, sr_d;
    logic              buf_full_q, buf_full_d;
    logic [3:0]        buf_sym_q, buf_sym_d;
    logic              chip_i_q, chip_i_d;
    logic              chip_q_q, chip_q_d;
    logic              en_i_q, en_i_d;
    logic              en_q_q, en_q_d;

    logic              accept;
    logic              load;
    logic              bypass;
    logic [NB_P_W-1:0] nbp_in;
    logic [3:0]        lut_sym;
    logic [31:0]       lut_chips;

    assign accept  = i_sym_valid && !buf_full_q;
    assign nbp_in  = (i_nb_P < NBP_FLOOR) ? NBP_FLOOR : i_nb_P;
    assign lut_sym = bypass ? i_sym : buf_sym_q;

    tx_pn_lut u_lut (
        .sym_i   (lut_sym),
        .chips_o (lut_chips)
    );

    // Next state: chip counter, symbol sequencing, holding register.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nbp_d      = nbp_q;
        idx_d      = idx_q;
        sr_d       = sr_q;
        buf_full_d = buf_full_q;
        buf_sym_d  = buf_sym_q;
        chip_i_d   = chip_i_q;
        chip_q_d   = chip_q_q;
        en_i_d     = 1'b0;
        en_q_d     = 1'b0;
        load       = 1'b0;
        bypass     = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d    = '0;
                idx_d    = '0;
                chip_i_d = 1'b0;
                chip_q_d = 1'b0;
                nbp_d    = nbp_in;
                if (i_tick && buf_full_q) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (i_tick) begin
                    if (cnt_q == '0) begin
                        nbp_d = nbp_in;
                        sr_d  = sr_q >> 1;
                        if (!idx_q[0]) begin
                            chip_i_d = sr_q[0];
                            en_i_d   = 1'b1;
                        end else begin
                            chip_q_d = sr_q[0];
                            en_q_d   = 1'b1;
                        end
                    end
                    if (cnt_q == nbp_q - ONE) begin
                        cnt_d = '0;
                        idx_d = idx_q + 5'd1;
                        if (idx_q == 5'd31) begin
                            if (buf_full_q) begin
                                load = 1'b1;
                            end else if (accept) begin
                                load   = 1'b1;
                                bypass = 1'b1;
                            end else begin
                                state_d  = IDLE;
                                chip_i_d = 1'b0;
                                chip_q_d = 1'b0;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            sr_d = lut_chips;
        end
        if (accept && !bypass) begin
            buf_full_d = 1'b1;
            buf_sym_d  = i_sym;
        end
        if (load && !bypass) begin
            buf_full_d = 1'b0;
        end
    end

    // State registers; reset drops any symbol in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            nbp_q      <= NBP_FLOOR;
            idx_q      <= '0;
            sr_q       <= '0;
            buf_full_q <= 1'b0;
            buf_sym_q  <= '0;
            chip_i_q   <= 1'b0;
            chip_q_q   <= 1'b0;
            en_i_q     <= 1'b0;
            en_q_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nbp_q      <= nbp_d;
            idx_q      <= idx_d;
            sr_q       <= sr_d;
            buf_full_q <= buf_full_d;
            buf_sym_q  <= buf_sym_d;
            chip_i_q   <= chip_i_d;
            chip_q_q   <= chip_q_d;
            en_i_q     <= en_i_d;
            en_q_q     <= en_q_d;
        end
    end

    assign o_sym_ready = !buf_full_q;
    assign o_chip_i    = chip_i_q;
    assign o_chip_q    = chip_q_q;
    assign o_en_i      = en_i_q;
    assign o_en_q      = en_q_q;
    assign o_busy      = (state_q == RUN);

endmodule

// File: tb/tb_tx_chip_gen.sv
// Directed bench for tx_chip_gen: chip order, strobe timing,
// back-to-back and bypass symbols, period change, reset.
module tb_tx_chip_gen;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_tick;
    logic [5:0] i_nb_P;
    logic [3:0] i_sym;
    logic       i_sym_valid;
    logic       o_sym_ready;
    logic       o_chip_i;
    logic       o_chip_q;
    logic       o_en_i;
    logic       o_en_q;
    logic       o_busy;

    always #5 clk = ~clk;

    tx_chip_gen #(.NB_P_W(6)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_tick      (i_tick),
        .i_nb_P      (i_nb_P),
        .i_sym       (i_sym),
        .i_sym_valid (i_sym_valid),
        .o_sym_ready (o_sym_ready),
        .o_chip_i    (o_chip_i),
        .o_chip_q    (o_chip_q),
        .o_en_i      (o_en_i),
        .o_en_q      (o_en_q),
        .o_busy      (o_busy)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int tick_cnt = 0;
    bit tick_at_edge = 1'b0;
    bit tick_tgl = 1'b0;

    bit ch_q[$];
    bit isq_q[$];
    int ts_q[$];
    int cy_q[$];
    int busy_cnt = 0;
    int both_cnt = 0;
    int bad_cnt = 0;

    int b_ev, b_busy, b_both, b_bad;
    int acc, acc2;

    // Edge and tick counters.
    always @(posedge clk) begin
        cyc++;
        if (i_tick) tick_cnt++;
        tick_at_edge = i_tick;
    end

    // Tick pattern: steady high, or toggling every cycle.
    always @(negedge clk) begin
        i_tick = tick_tgl ? ~i_tick : 1'b1;
    end

    // Strobe monitor: log each chip with tick and cycle stamps.
    always @(negedge clk) begin
        if (o_en_i || o_en_q) begin
            ch_q.push_back(o_en_i ? o_chip_i : o_chip_q);
            isq_q.push_back(o_en_q);
            ts_q.push_back(tick_cnt);
            cy_q.push_back(cyc);
            if (!tick_at_edge) bad_cnt++;
        end
        if (o_en_i && o_en_q) both_cnt++;
        if (o_busy) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic mark();
        b_ev   = ch_q.size();
        b_busy = busy_cnt;
        b_both = both_cnt;
        b_bad  = bad_cnt;
    endtask

    function automatic int ts(input int k);
        if (b_ev + k < ts_q.size()) return ts_q[b_ev+k];
        return -100000;
    endfunction

    function automatic int cy(input int k);
        if (b_ev + k < cy_q.size()) return cy_q[b_ev+k];
        return -100000;
    endfunction

    // First chip ends up in the MSB.
    function automatic logic [31:0] seq32(input int st);
        logic [31:0] r = '0;
        for (int k = 0; k < 32; k++)
            r = {r[30:0], (st + k < ch_q.size()) ? ch_q[st+k] : 1'b0};
        return r;
    endfunction

    function automatic logic [31:0] rail32(input int st);
        logic [31:0] r = '0;
        for (int k = 0; k < 32; k++)
            r = {r[30:0], (st + k < isq_q.size()) ? isq_q[st+k] : 1'b1};
        return r;
    endfunction

    task automatic send(input logic [3:0] s, output int a);
        bit ok = 1'b0;
        a = -1;
        @(negedge clk);
        i_sym = s;
        i_sym_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (o_sym_ready) begin
                a  = cyc + 1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        i_sym_valid = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (o_busy) seen = 1'b1;
            else if (seen) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        i_tick = 1'b1;
        i_nb_P = 6'd4;
        i_sym = 4'd7;
        i_sym_valid = 1'b1;

        // 1: reset with valid held high
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_ready", o_sym_ready, 1);
        chk("t1_outs", {o_chip_i, o_chip_q, o_en_i, o_en_q, o_busy}, 0);
        i_rst = 1'b0;
        i_sym_valid = 1'b0;
        @(negedge clk);
        chk("t1_noacc", {o_sym_ready, o_busy}, 2'b10);

        // 2: single symbol 0, period 4
        mark();
        send(4'd0, acc);
        wait_idle("t2_done", 400);
        chk("t2_nchips", ch_q.size() - b_ev, 32);
        chk("t2_seq", seq32(b_ev), 32'hD9C3_522E);
        chk("t2_rails", rail32(b_ev), 32'h5555_5555);
        chk("t2_lat", cy(0) - acc, 2);
        chk("t2_ispace", ts(2) - ts(0), 8);
        chk("t2_qoff", ts(1) - ts(0), 4);
        chk("t2_span", ts(31) - ts(0), 124);
        chk("t2_busy", busy_cnt - b_busy, 128);
        chk("t2_both", both_cnt - b_both, 0);
        chk("t2_outs", {o_chip_i, o_chip_q, o_en_i, o_en_q, o_busy}, 0);

        // 3: symbols 3 then 11 back to back
        mark();
        send(4'd3, acc);
        send(4'd11, acc2);
        wait_idle("t3_done", 600);
        chk("t3_nchips", ch_q.size() - b_ev, 64);
        chk("t3_seq3", seq32(b_ev), 32'h22ED_9C35);
        chk("t3_seq11", seq32(b_ev + 32), 32'h77B8_C960);
        chk("t3_gap", ts(32) - ts(31), 4);
        chk("t3_busy", busy_cnt - b_busy, 256);

        // 4: symbol 5 offered in the wrap cycle of symbol 0
        mark();
        send(4'd0, acc);
        repeat (128) @(posedge clk);
        @(negedge clk);
        chk("t4_ready", o_sym_ready, 1);
        i_sym = 4'd5;
        i_sym_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_sym_valid = 1'b0;
        chk("t4_bypass", {o_sym_ready, o_busy}, 2'b11);
        wait_idle("t4_done", 400);
        chk("t4_nchips", ch_q.size() - b_ev, 64);
        chk("t4_seq0", seq32(b_ev), 32'hD9C3_522E);
        chk("t4_seq5", seq32(b_ev + 32), 32'h3522_ED9C);
        chk("t4_gap", ts(32) - ts(31), 4);
        chk("t4_busy", busy_cnt - b_busy, 256);

        // 5: period 4 -> 6 mid chip 0, tick toggling
        tick_tgl = 1'b1;
        mark();
        send(4'd0, acc);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ch_q.size() > b_ev) break;
        end
        i_nb_P = 6'd6;
        wait_idle("t5_done", 2000);
        chk("t5_c0c1", ts(1) - ts(0), 4);
        chk("t5_c1c2", ts(2) - ts(1), 6);
        chk("t5_c2c3", ts(3) - ts(2), 6);
        chk("t5_cycles", cy(2) - cy(0), 20);
        chk("t5_span", ts(31) - ts(0), 184);
        chk("t5_seq", seq32(b_ev), 32'hD9C3_522E);
        chk("t5_notick", bad_cnt - b_bad, 0);
        tick_tgl = 1'b0;
        i_nb_P = 6'd4;
        @(negedge clk);

        // 6: reset after chip 17, then a fresh symbol 8
        mark();
        send(4'd0, acc);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ch_q.size() - b_ev >= 18) break;
        end
        chk("t6_reached", ch_q.size() - b_ev, 18);
        i_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        chk("t6_outs", {o_chip_i, o_chip_q, o_en_i, o_en_q, o_busy, o_sym_ready}, 6'b000001);
        mark();
        send(4'd8, acc);
        wait_idle("t6_done", 400);
        chk("t6_nchips", ch_q.size() - b_ev, 32);
        chk("t6_seq8", seq32(b_ev), 32'h8C96_077B);
        chk("t6_lat", cy(0) - acc, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tx_chip_gen.md
# tx_chip_gen

Transmit-side chip timing generator and DSSS spreader for the 802.15.4 2.4 GHz O-QPSK path. It accepts 4-bit data symbols over a valid/ready handshake and expands each one into its 32-chip PN sequence. It emits even chips on the I rail and odd chips on the Q rail, with Q offset by one chip period. The chip period is `i_nb_P` prescaler ticks, the same time base the receive-side CDR counter recovers. The block sits between the symbol mapper and the half-sine pulse shaper.

## Interface
- `NB_P_W`, default 6: width of the chip-period input.
- `i_clk` in 1: system clock.
- `i_rst` in 1: synchronous reset, active-high. This is one clock with a synchronous active-high reset.
- `i_tick` in 1: prescaler enable; all timing advances only on cycles where it is 1.
- `i_nb_P` in NB_P_W: ticks per chip period Tc; legal range is 4..63.
- `i_sym` in 4: data symbol, value 0..15.
- `i_sym_valid` in 1: symbol offered.
- `o_sym_ready` in/out: out, 1 bit; symbol accepted when `i_sym_valid && o_sym_ready`.
- `o_chip_i` out 1: I-rail chip, held between updates.
- `o_chip_q` out 1: Q-rail chip, held between updates.
- `o_en_i` out 1: one-cycle strobe, asserted in the cycle `o_chip_i` takes a new value.
- `o_en_q` out 1: one-cycle strobe for `o_chip_q`.
- `o_busy` out 1: high while the FSM is in RUN.

## Operation
- **Holding register.** One-entry register, `buf_full`/`buf_sym`.
  - `o_sym_ready = !buf_full`.
  - An accept sets `buf_full`; a load into the spreader clears it.
- **FSM states.**
  - IDLE:
    - `cnt = 0`, `chip_idx = 0`, chip outputs 0.
    - If `buf_full`, load `buf_sym` into the PN shift register and go to RUN.
  - RUN, on each `i_tick`:
    - If `cnt == 0`, drive chip `chip_idx` to I when `chip_idx` is even, or to Q when it is odd, and pulse the matching strobe.
    - If `cnt == nbp_q-1`, set `cnt <= 0` and increment `chip_idx`; otherwise increment `cnt`.
- **Symbol wrap** (`chip_idx == 31` and `cnt == nbp_q-1` on a tick):
  - If `buf_full`, load `buf_sym`, set `chip_idx <= 0`, stay in RUN. Consecutive symbols have no gap.
  - Else, if an accept happens in this same cycle, bypass: load `i_sym` directly and leave `buf_full` at 0.
  - Otherwise go to IDLE and clear `o_chip_i` and `o_chip_q` to 0.
- **Chip period.** `nbp_q` latches `i_nb_P` in IDLE and on every `cnt == 0` tick in RUN. A change mid-chip takes effect at the next chip boundary.
- **PN mapping.**
  - Symbol 0 = c0..c31 = 1101 1001 1100 0011 0101 0010 0010 1110.
  - Symbols s = 1..7 are symbol 0 cyclically shifted right by 4·s chips.
  - Symbols 8..15 are symbols 0..7 with every odd-indexed chip inverted.
- **Counter width.** `cnt` is NB_P_W bits; `chip_idx` is 5 bits.
- **Out-of-range `i_nb_P`.** Values below 4 are clamped to 4 at latch time.
- **Reset.** Asserting `i_rst`, including mid-symbol, forces:
  - state IDLE;
  - `cnt`, `chip_idx`, `buf_full` = 0;
  - all outputs 0;
  - `o_sym_ready` 1 from the first cycle after reset.

  Any symbol in flight is discarded.

## Timing
- Accept at edge t (IDLE, buffer empty, continuous ticks):
  - `buf_full` at t+1;
  - RUN at t+2;
  - `o_en_i = 1` with `o_chip_i = c0` after edge t+3.
- Strobes:
  - I updates every 2·nbp_q ticks.
  - `o_en_q` first fires nbp_q ticks after the first `o_en_i`, then every 2·nbp_q ticks.
  - `o_en_i` and `o_en_q` are never asserted together.
- Symbol duration is exactly 32·nbp_q ticks.
- With `i_tick = 0`, all state freezes and no strobes are issued.
- Handshake accepts are independent of `i_tick`.

## Structure
- `zigbee_pkg` holds:
  - `PN_SYM0` (32-bit constant);
  - function `pn_chips(sym)` returning the 32-bit sequence;
  - FSM enum `tx_state_t {IDLE, RUN}`;
  - `NB_P_MIN = 4`.
- One combinational sub-module `tx_pn_lut` maps the 4-bit symbol to 32 chips. Counter, FSM and buffer live in the top module.

## Test plan
1. Reset held for 3 cycles with `i_sym_valid = 1` → all outputs 0, no accept; `o_sym_ready = 1` from the first post-reset cycle.
2. Symbol 0, `nb_P = 4`, `i_tick = 1` → I chips 1,0,1,0,1,0,0,1,… and Q chips 1,1,0,1,…; `o_en_i` spacing 8 cycles; first `o_en_q` 4 cycles after the first `o_en_i`; IDLE and outputs 0 after 128 cycles.
3. Symbols 3 then 11 offered back-to-back → chip 0 of symbol 11 directly follows chip 31 of symbol 3 with no gap; symbol 11 equals symbol 3 with odd chips inverted.
4. Wrap-cycle bypass: symbol offered exactly in the wrap cycle with the buffer empty → accepted, no gap; `buf_full` stays 0.
5. `i_nb_P` changed 4→6 mid-chip, and `i_tick` toggled 1/0 → new period applies from the next chip; strobe spacing counts ticks only.
6. `i_rst` pulsed at chip 17 → outputs 0 next cycle; a fresh symbol afterwards restarts at c0.
